// File: rtl/wb_iprefetch_pkg.sv
// wb_iprefetch_pkg
//   Shared definitions for the instruction prefetch buffer:
//   - pf_state_t : controller states (PF_IDLE, PF_STREAM, PF_DRAIN)
//   - ADR_LSB    : number of byte-offset bits dropped from fetch addresses
//   - word_aw()  : word-address width for a given byte-address width
package wb_iprefetch_pkg;

  typedef enum logic [1:0] {
    PF_IDLE   = 2'd0,
    PF_STREAM = 2'd1,
    PF_DRAIN  = 2'd2
  } pf_state_t;

  localparam int ADR_LSB = 2;

  function automatic int word_aw(input int aw);
    return aw - ADR_LSB;
  endfunction

endpackage

// File: rtl/wb_iprefetch_fifo.sv
// wb_iprefetch_fifo
//   DEPTH x 32 circular buffer holding prefetched instruction words.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     clear         empties the buffer (wins over push/pop)
//     push, push_data  write one word at the tail
//     pop           read one word from the head; data appears on rd_data
//                   the following cycle (registered)
//     rd_data       registered read data
//     count         number of buffered words, 0..DEPTH
//   The caller never pushes when full nor pops when empty.
module wb_iprefetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [31:0]              push_data,
  input  logic                     pop,
  output logic [31:0]              rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage carries no reset; only valid entries are ever read.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_iprefetch.sv
// wb_iprefetch
//   Instruction prefetch buffer between a CPU instruction Wishbone master
//   (s_*) and the SoC interconnect (m_*). Streams sequential words ahead of
//   the CPU; a sequential fetch that hits the buffer is acknowledged the
//   cycle after the request, anything else restarts the stream.
//   Ports:
//     wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//     s_adr_i/s_cyc_i/s_stb_i CPU fetch request (byte address, [1:0] ignored)
//     s_dat_o/s_ack_o         instruction word and one-cycle acknowledge
//     m_adr_o/m_cyc_o/m_stb_o interconnect request (word aligned)
//     m_dat_i/m_ack_i         interconnect read data and acknowledge
//     flush_i                 one-cycle pulse discarding buffered words
//     dbg_state               current controller state
//   Handshake: both sides are Wishbone classic reads. A master request is
//   held with a stable address until m_ack_i; the cycle that carries
//   m_ack_i completes it, and a new request may start the very next cycle.
//   A CPU request counts only while s_ack_o is low, so the ack cycle itself
//   is never taken as a new request.
module wb_iprefetch
  import wb_iprefetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [AW-1:0] s_adr_i,
  input  logic          s_cyc_i,
  input  logic          s_stb_i,
  output logic [31:0]   s_dat_o,
  output logic          s_ack_o,
  output logic [AW-1:0] m_adr_o,
  output logic          m_cyc_o,
  output logic          m_stb_o,
  input  logic [31:0]   m_dat_i,
  input  logic          m_ack_i,
  input  logic          flush_i,
  output pf_state_t     dbg_state
);

  localparam int WA = word_aw(AW);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int NW = CW + 1;

  pf_state_t      state;
  logic [WA-1:0]  head_adr;
  logic [WA-1:0]  fetch_adr;
  logic [WA-1:0]  miss_adr;
  logic           busy;
  logic           drain_flush;
  logic           sel_byp;
  logic [31:0]    byp_data;
  logic [31:0]    fifo_rd_data;
  logic [CW-1:0]  count;

  logic           req;
  logic [WA-1:0]  req_w;
  logic           in_stream;
  logic           nonempty;
  logic           hit;
  logic           bypass;
  logic           miss;
  logic           abort;
  logic           take_hit;
  logic           take_byp;
  logic           m_done;
  logic           start;
  logic           push;
  logic           pop;
  logic           clear;
  logic [NW-1:0]  next_cnt;
  logic [WA-1:0]  fetch_inc;
  logic [WA-1:0]  head_inc;
  logic           unused_adr_bits;

  assign unused_adr_bits = ^s_adr_i[ADR_LSB-1:0];

  always_comb begin
    req       = s_cyc_i & s_stb_i & ~s_ack_o;
    req_w     = s_adr_i[AW-1:ADR_LSB];
    in_stream = (state == PF_STREAM);
    nonempty  = (count != '0);
    m_done    = busy & m_ack_i;
    fetch_inc = fetch_adr + 1'b1;
    head_inc  = head_adr + 1'b1;
    hit       = req & in_stream & nonempty & (req_w == head_adr);
    // Empty buffer, and the word the CPU wants is completing right now.
    bypass    = req & in_stream & ~nonempty & m_done &
                (m_adr_o[AW-1:ADR_LSB] == req_w);
    // With an empty buffer and fetch_adr already at the request, the
    // request simply waits for the stream to deliver it.
    miss      = req & in_stream & ~hit & ~bypass &
                (nonempty ? (req_w != head_adr) : (req_w != fetch_adr));
    abort     = in_stream & (miss | flush_i);
    take_hit  = hit & ~flush_i;
    take_byp  = bypass & ~flush_i;
    start     = (state == PF_IDLE) & req & ~flush_i;
    pop       = take_hit;
    push      = in_stream & m_done & ~abort & ~take_byp;
    clear     = abort | start;
    next_cnt  = {1'b0, count} + NW'(push) - NW'(pop);
  end

  wb_iprefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .clear     (clear),
    .push      (push),
    .push_data (m_dat_i),
    .pop       (pop),
    .rd_data   (fifo_rd_data),
    .count     (count)
  );

  // busy is the outstanding-transfer flag; tying cyc/stb straight to it
  // lets the asynchronous reset drop the bus request immediately.
  assign m_cyc_o   = busy;
  assign m_stb_o   = busy;
  assign s_dat_o   = sel_byp ? byp_data : fifo_rd_data;
  assign dbg_state = state;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= PF_IDLE;
      head_adr    <= '0;
      fetch_adr   <= '0;
      miss_adr    <= '0;
      busy        <= 1'b0;
      drain_flush <= 1'b0;
      sel_byp     <= 1'b0;
      byp_data    <= '0;
      s_ack_o     <= 1'b0;
      m_adr_o     <= '0;
    end else begin
      s_ack_o <= 1'b0;
      case (state)
        PF_IDLE: begin
          if (start) begin
            head_adr  <= req_w;
            fetch_adr <= req_w;
            m_adr_o   <= {req_w, 2'b00};
            busy      <= 1'b1;
            state     <= PF_STREAM;
          end
        end

        PF_STREAM: begin
          if (abort) begin
            if (busy && !m_ack_i) begin
              // Wishbone cannot abandon a strobed transfer: wait it out.
              state       <= PF_DRAIN;
              miss_adr    <= req_w;
              drain_flush <= flush_i;
            end else if (flush_i) begin
              busy  <= 1'b0;
              state <= PF_IDLE;
            end else begin
              head_adr  <= req_w;
              fetch_adr <= req_w;
              m_adr_o   <= {req_w, 2'b00};
              busy      <= 1'b1;
            end
          end else begin
            if (take_hit || take_byp) begin
              s_ack_o  <= 1'b1;
              sel_byp  <= take_byp;
              head_adr <= head_inc;
            end
            if (take_byp) byp_data <= m_dat_i;
            if (m_done) begin
              fetch_adr <= fetch_inc;
              // Chain the next transfer only if it still has a slot.
              if (next_cnt < NW'(DEPTH)) m_adr_o <= {fetch_inc, 2'b00};
              else                       busy    <= 1'b0;
            end else if (!busy && count < CW'(DEPTH)) begin
              m_adr_o <= {fetch_adr, 2'b00};
              busy    <= 1'b1;
            end
          end
        end

        PF_DRAIN: begin
          if (m_ack_i) begin
            if (drain_flush) begin
              busy  <= 1'b0;
              state <= PF_IDLE;
            end else begin
              head_adr  <= miss_adr;
              fetch_adr <= miss_adr;
              m_adr_o   <= {miss_adr, 2'b00};
              state     <= PF_STREAM;
            end
          end
        end

        default: state <= PF_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_iprefetch.sv
// tb_wb_iprefetch
//   Directed bench for wb_iprefetch: ROM responder with programmable wait
//   states, CPU fetch driver task, table-driven sequential and hit runs,
//   and hand-written sequences for miss, drain, flush, wrap and reset.
module tb_wb_iprefetch;
  import wb_iprefetch_pkg::*;

  // ---------------- clock / reset ----------------
  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  always #5 wb_clk_i = ~wb_clk_i;

  logic [31:0] s_adr_i = '0;
  logic        s_cyc_i = 1'b0;
  logic        s_stb_i = 1'b0;
  logic [31:0] s_dat_o;
  logic        s_ack_o;
  logic [31:0] m_adr_o;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic [31:0] m_dat_i = '0;
  logic        m_ack_i = 1'b0;
  logic        flush_i = 1'b0;
  pf_state_t   dbg_state;

  wb_iprefetch #(.DEPTH(4), .AW(32)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .s_adr_i   (s_adr_i),
    .s_cyc_i   (s_cyc_i),
    .s_stb_i   (s_stb_i),
    .s_dat_o   (s_dat_o),
    .s_ack_o   (s_ack_o),
    .m_adr_o   (m_adr_o),
    .m_cyc_o   (m_cyc_o),
    .m_stb_o   (m_stb_o),
    .m_dat_i   (m_dat_i),
    .m_ack_i   (m_ack_i),
    .flush_i   (flush_i),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ack_adr_q[$];
  int          dbl_ack = 0;
  logic        prev_ack = 1'b0;
  int          rom_lat = 1;
  int          wait_cnt = 0;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ROM: acks after rom_lat extra cycles of a held strobe.
  initial begin
    forever begin
      @(posedge wb_clk_i); #1;
      if (wb_rst_i || !m_stb_o) begin
        m_ack_i  = 1'b0;
        wait_cnt = 0;
      end else if (wait_cnt >= rom_lat) begin
        m_ack_i  = 1'b1;
        m_dat_i  = rom_word(m_adr_o);
        wait_cnt = 0;
      end else begin
        m_ack_i  = 1'b0;
        wait_cnt++;
      end
    end
  end

  // Monitor: completed master transfers and back-to-back CPU acks.
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i) begin
      if (m_stb_o && m_ack_i) ack_adr_q.push_back(m_adr_o);
      if (s_ack_o && prev_ack) dbl_ack++;
      prev_ack = s_ack_o;
    end else begin
      prev_ack = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    wb_rst_i = 1'b1;
    s_cyc_i  = 1'b0;
    s_stb_i  = 1'b0;
    flush_i  = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    ack_adr_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  // Issues one CPU fetch (optionally with flush_i in the request cycle).
  // lat counts cycles from the request cycle to the ack cycle.
  task automatic cpu_fetch(input string name, input logic [31:0] a, input bit fl,
                           output logic [31:0] d, output int lat,
                           output logic [31:0] madr1, output logic [31:0] st1);
    bit got;
    got   = 1'b0;
    d     = '0;
    lat   = 0;
    madr1 = '0;
    st1   = '0;
    @(posedge wb_clk_i); #1;
    s_adr_i = a;
    s_cyc_i = 1'b1;
    s_stb_i = 1'b1;
    flush_i = fl;
    for (int i = 0; i < 200; i++) begin
      @(posedge wb_clk_i); #1;
      flush_i = 1'b0;
      lat++;
      if (lat == 1) begin
        madr1 = m_adr_o;
        st1   = 32'(dbg_state);
      end
      if (s_ack_o) begin
        d   = s_dat_o;
        got = 1'b1;
        break;
      end
    end
    s_cyc_i = 1'b0;
    s_stb_i = 1'b0;
    check({name, "_ack_seen"}, 32'(got), 32'd1);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] adr;
    int          lat;
    logic [31:0] dat;
  } vec_t;

  vec_t seq_v[8];
  vec_t hit_v[4];

  logic [31:0] d;
  logic [31:0] madr1;
  logic [31:0] st1;
  int          lat;

  initial begin
    seq_v[0] = '{32'h0000_0000, 3, 32'hDEAD_BEEF};
    seq_v[1] = '{32'h0000_0004, 1, 32'hDEAD_BEEB};
    seq_v[2] = '{32'h0000_0008, 1, 32'hDEAD_BEE7};
    seq_v[3] = '{32'h0000_000C, 1, 32'hDEAD_BEE3};
    seq_v[4] = '{32'h0000_0010, 1, 32'hDEAD_BEFF};
    seq_v[5] = '{32'h0000_0014, 1, 32'hDEAD_BEFB};
    seq_v[6] = '{32'h0000_0018, 1, 32'hDEAD_BEF7};
    seq_v[7] = '{32'h0000_001C, 1, 32'hDEAD_BEF3};
    hit_v[0] = '{32'h0000_0004, 1, 32'hDEAD_BEEB};
    hit_v[1] = '{32'h0000_0008, 1, 32'hDEAD_BEE7};
    hit_v[2] = '{32'h0000_000C, 1, 32'hDEAD_BEE3};
    hit_v[3] = '{32'h0000_0010, 1, 32'hDEAD_BEFF};

    // ---- reset values ----
    do_reset();
    check("rst_s_ack", 32'(s_ack_o), 32'd0);
    check("rst_s_dat", s_dat_o, 32'd0);
    check("rst_m_cyc", 32'(m_cyc_o), 32'd0);
    check("rst_m_stb", 32'(m_stb_o), 32'd0);
    check("rst_m_adr", m_adr_o, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(PF_IDLE));

    // ---- sequential run, L=1 ----
    rom_lat = 1;
    for (int i = 0; i < 8; i++) begin
      cpu_fetch($sformatf("seq%0d", i), seq_v[i].adr, 1'b0, d, lat, madr1, st1);
      check($sformatf("seq%0d_data", i), d, seq_v[i].dat);
      check($sformatf("seq%0d_lat", i), 32'(lat), 32'(seq_v[i].lat));
      check($sformatf("seq%0d_ahead_le4", i),
            32'(((m_adr_o - seq_v[i].adr) >> 2) <= 32'd4), 32'd1);
    end

    // ---- full buffer: CPU idle after fetching 0x0 ----
    do_reset();
    rom_lat = 1;
    cpu_fetch("full0", 32'h0, 1'b0, d, lat, madr1, st1);
    ack_adr_q.delete();
    idle(20);
    check("full_m_cyc_low", 32'(m_cyc_o), 32'd0);
    exp_q = '{32'h4, 32'h8, 32'hC, 32'h10};
    check("full_xfer_cnt", 32'(ack_adr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < ack_adr_q.size(); i++)
      check($sformatf("full_xfer%0d_adr", i), ack_adr_q[i], exp_q[i]);
    for (int i = 0; i < 4; i++) begin
      cpu_fetch($sformatf("hit%0d", i), hit_v[i].adr, 1'b0, d, lat, madr1, st1);
      check($sformatf("hit%0d_data", i), d, hit_v[i].dat);
      check($sformatf("hit%0d_lat", i), 32'(lat), 32'(hit_v[i].lat));
    end

    // ---- branch miss: buffer holds 0x100..0x10C, CPU jumps to 0x200 ----
    do_reset();
    rom_lat = 1;
    cpu_fetch("br0", 32'h0FC, 1'b0, d, lat, madr1, st1);
    check("br0_data", d, 32'hDEAD_BE13);
    idle(20);
    check("br_full_m_cyc_low", 32'(m_cyc_o), 32'd0);
    cpu_fetch("br1", 32'h200, 1'b0, d, lat, madr1, st1);
    check("br_next_m_adr", madr1, 32'h200);
    check("br_state", st1, 32'(PF_STREAM));
    check("br_data", d, 32'hDEAD_BCEF);
    check("br_lat", 32'(lat), 32'd3);

    // ---- miss while a slow transfer is outstanding -> DRAIN ----
    do_reset();
    rom_lat = 5;
    cpu_fetch("dr0", 32'h0, 1'b0, d, lat, madr1, st1);
    check("dr0_data", d, 32'hDEAD_BEEF);
    check("dr0_lat", 32'(lat), 32'd7);
    ack_adr_q.delete();
    cpu_fetch("dr1", 32'h40, 1'b0, d, lat, madr1, st1);
    check("dr_state", st1, 32'(PF_DRAIN));
    check("dr_data", d, 32'hDEAD_BEAF);
    check("dr_lat", 32'(lat), 32'd11);
    exp_q = '{32'h4, 32'h40};
    check("dr_xfer_cnt", 32'(ack_adr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < ack_adr_q.size(); i++)
      check($sformatf("dr_xfer%0d_adr", i), ack_adr_q[i], exp_q[i]);

    // ---- flush coincident with a hit ----
    do_reset();
    rom_lat = 1;
    cpu_fetch("fl0", 32'h0, 1'b0, d, lat, madr1, st1);
    idle(20);
    check("fl_full_m_cyc_low", 32'(m_cyc_o), 32'd0);
    ack_adr_q.delete();
    cpu_fetch("fl1", 32'h4, 1'b1, d, lat, madr1, st1);
    check("fl_state_after", st1, 32'(PF_IDLE));
    check("fl_lat", 32'(lat), 32'd4);
    check("fl_data", d, 32'hDEAD_BEEB);
    check("fl_refetch_nonempty", 32'(ack_adr_q.size() > 0), 32'd1);
    if (ack_adr_q.size() > 0) check("fl_refetch_adr", ack_adr_q[0], 32'h4);

    // ---- address wrap, then reset in the middle of a transfer ----
    do_reset();
    rom_lat = 1;
    cpu_fetch("wr0", 32'hFFFF_FFFC, 1'b0, d, lat, madr1, st1);
    check("wr_data", d, 32'h2152_4113);
    check("wr_lat", 32'(lat), 32'd3);
    check("wr_next_m_adr", m_adr_o, 32'h0);
    check("wr_next_m_stb", 32'(m_stb_o), 32'd1);
    #2 wb_rst_i = 1'b1;
    #1;
    check("arst_m_cyc", 32'(m_cyc_o), 32'd0);
    check("arst_m_stb", 32'(m_stb_o), 32'd0);
    check("arst_m_adr", m_adr_o, 32'd0);
    check("arst_state", 32'(dbg_state), 32'(PF_IDLE));
    @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    idle(2);

    check("s_ack_single_cycle", 32'(dbl_ack), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
